mac_tcdm_responder: RTL and testbench

- TCDM slave (responder) that serves the request side of the MAC streamer's TCDM master ports: NP request ports share one single-ported word memory of DEPTH 32-bit words.
- Serves the loads of the a/b/c sources and the stores of the d sink.
- One grant per cycle via round-robin arbitration; fixed one-cycle response latency.
- Serves as the cluster-memory model in the MAC engine testbench and as a small private scratchpad in standalone integration.

---
 rtl/mac_package.sv | 19 +
 rtl/mac_rr_arbiter.sv | 51 +++++
 rtl/mac_tcdm_responder.sv | 109 ++++++++++
 tb/tb_mac_tcdm_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mac_package.sv
// Shared TCDM types for the MAC streamer memory side.
package mac_package;

    localparam int unsigned TCDM_DW  = 32;
    localparam int unsigned TCDM_BEW = 4;

    typedef struct packed {
        logic [TCDM_DW-1:0]  add;
        logic                wen;
        logic [TCDM_BEW-1:0] be;
        logic [TCDM_DW-1:0]  data;
    } tcdm_req_t;

    typedef struct packed {
        logic [TCDM_DW-1:0] r_data;
        logic               r_valid;
    } tcdm_resp_t;

endpackage

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter: one-hot grant per cycle, search starts after the last winner.
module mac_rr_arbiter #(
    parameter int unsigned NP = 4,
    localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          stall_i,
    input  logic [NP-1:0] req_i,
    output logic [NP-1:0] gnt_o,
    output logic [IW-1:0] winner_o,
    output logic          valid_o
);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic          found;
    logic          valid;

    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NP; i++) begin
            cand = IW'((32'(rr_ptr_q) + i) % NP);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        valid = found && !stall_i;

        gnt_o = '0;
        if (valid) gnt_o[winner] = 1'b1;

        rr_ptr_d = rr_ptr_q;
        if (clear_i)    rr_ptr_d = IW'(NP - 1);
        else if (valid) rr_ptr_d = winner;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rr_ptr_q <= IW'(NP - 1);
        else         rr_ptr_q <= rr_ptr_d;
    end

    assign winner_o = winner;
    assign valid_o  = valid;

endmodule

// File: rtl/mac_tcdm_responder.sv
// Multi-port TCDM responder: shared single-ported word memory, round-robin
// arbitration and a fixed one-cycle response.
module mac_tcdm_responder
    import mac_package::*;
#(
    parameter int unsigned NP    = 4,
    parameter int unsigned DEPTH = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic [NP-1:0]    tcdm_req_i,
    output logic [NP-1:0]    tcdm_gnt_o,
    input  logic [NP*32-1:0] tcdm_add_i,
    input  logic [NP-1:0]    tcdm_wen_i,
    input  logic [NP*4-1:0]  tcdm_be_i,
    input  logic [NP*32-1:0] tcdm_data_i,
    output logic [NP*32-1:0] tcdm_r_data_o,
    output logic [NP-1:0]    tcdm_r_valid_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1;

    tcdm_req_t          req_s [NP];
    tcdm_req_t          sel;
    logic [IW-1:0]      winner;
    logic               gnt_valid;
    logic [AW-1:0]      word_idx;
    logic [TCDM_DW-1:0] mem_rd;
    logic [TCDM_DW-1:0] wr_word_d;
    logic               unused_add;

    logic [TCDM_DW-1:0] mem_q [DEPTH];

    tcdm_resp_t    resp_q, resp_d;
    logic [IW-1:0] port_q, port_d;

    always_comb begin
        for (int unsigned p = 0; p < NP; p++) begin
            req_s[p].add  = tcdm_add_i[p*32 +: 32];
            req_s[p].wen  = tcdm_wen_i[p];
            req_s[p].be   = tcdm_be_i[p*4 +: 4];
            req_s[p].data = tcdm_data_i[p*32 +: 32];
        end
    end

    mac_rr_arbiter #(.NP(NP)) i_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .stall_i  (stall_i),
        .req_i    (tcdm_req_i),
        .gnt_o    (tcdm_gnt_o),
        .winner_o (winner),
        .valid_o  (gnt_valid)
    );

    assign sel        = req_s[winner];
    assign word_idx   = sel.add[AW+1:2];
    assign mem_rd     = mem_q[word_idx];
    // Byte offset and bits above the array size are dropped so addresses wrap.
    assign unused_add = ^{sel.add[TCDM_DW-1:AW+2], sel.add[1:0]};

    always_comb begin
        wr_word_d = mem_rd;
        for (int unsigned b = 0; b < TCDM_BEW; b++) begin
            if (sel.be[b]) wr_word_d[b*8 +: 8] = sel.data[b*8 +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_valid && !sel.wen) mem_q[word_idx] <= wr_word_d;
    end

    // Write acknowledges carry zero data so every grant yields a uniform response.
    always_comb begin
        resp_d = '0;
        port_d = '0;
        if (!clear_i && gnt_valid) begin
            resp_d.r_valid = 1'b1;
            resp_d.r_data  = sel.wen ? mem_rd : '0;
            port_d         = winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_q <= '0;
            port_q <= '0;
        end else begin
            resp_q <= resp_d;
            port_q <= port_d;
        end
    end

    always_comb begin
        tcdm_r_valid_o = '0;
        tcdm_r_data_o  = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (resp_q.r_valid && port_q == IW'(p)) begin
                tcdm_r_valid_o[p]       = 1'b1;
                tcdm_r_data_o[p*32 +: 32] = resp_q.r_data;
            end
        end
    end

endmodule

// File: tb/tb_mac_tcdm_responder.sv
// Directed bench for mac_tcdm_responder with hand-computed expectations.
module tb_mac_tcdm_responder;

    localparam int unsigned NP = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clear_i;
    logic            stall_i;
    logic [NP-1:0]   tcdm_req_i;
    logic [NP-1:0]   tcdm_gnt_o;
    logic [NP*32-1:0] tcdm_add_i;
    logic [NP-1:0]   tcdm_wen_i;
    logic [NP*4-1:0] tcdm_be_i;
    logic [NP*32-1:0] tcdm_data_i;
    logic [NP*32-1:0] tcdm_r_data_o;
    logic [NP-1:0]   tcdm_r_valid_o;

    int vectors    = 0;
    int miscompares = 0;

    mac_tcdm_responder #(.NP(NP), .DEPTH(1024)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .stall_i        (stall_i),
        .tcdm_req_i     (tcdm_req_i),
        .tcdm_gnt_o     (tcdm_gnt_o),
        .tcdm_add_i     (tcdm_add_i),
        .tcdm_wen_i     (tcdm_wen_i),
        .tcdm_be_i      (tcdm_be_i),
        .tcdm_data_i    (tcdm_data_i),
        .tcdm_r_data_o  (tcdm_r_data_o),
        .tcdm_r_valid_o (tcdm_r_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
        tcdm_req_i[p]          = 1'b1;
        tcdm_add_i[p*32 +: 32] = a;
        tcdm_wen_i[p]          = w;
        tcdm_be_i[p*4 +: 4]    = b;
        tcdm_data_i[p*32 +: 32] = d;
    endtask

    // p < 0 means no response expected this cycle.
    task automatic chk_resp(input string tag, input int p, input logic [31:0] d);
        logic [NP-1:0]    ev;
        logic [NP*32-1:0] ed;
        ev = '0;
        ed = '0;
        if (p >= 0) begin
            ev[p]          = 1'b1;
            ed[p*32 +: 32] = d;
        end
        chk({tag, "_valid"}, 128'(tcdm_r_valid_o), 128'(ev));
        chk({tag, "_data"},  128'(tcdm_r_data_o),  128'(ed));
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; stall_i = 1'b0;
        tcdm_req_i = '0; tcdm_add_i = '0; tcdm_wen_i = '0;
        tcdm_be_i = '0; tcdm_data_i = '0;
        tick(); tick();
        chk_resp("rst", -1, 32'h0);
        chk("idle_gnt", 128'(tcdm_gnt_o), 128'h0);
        rst_ni = 1'b1;

        // single write then read-after-write on port 0
        drive(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF); #1;
        chk("wr0_gnt", 128'(tcdm_gnt_o), 128'b0001);
        tick(); tcdm_req_i = '0;
        chk_resp("wr0_ack", 0, 32'h0);
        drive(0, 32'h10, 1'b1, 4'h0, 32'h0); #1;
        chk("rd0_gnt", 128'(tcdm_gnt_o), 128'b0001);
        tick(); tcdm_req_i = '0;
        chk_resp("rd0", 0, 32'hDEADBEEF);
        tick();
        chk_resp("rd0_pulse", -1, 32'h0);

        // byte-enable merge on port 1
        drive(1, 32'h20, 1'b0, 4'hF, 32'h11223344); #1;
        tick(); tcdm_req_i = '0;
        drive(1, 32'h20, 1'b0, 4'b0101, 32'hAABBCCDD); #1;
        chk("be_wr_gnt", 128'(tcdm_gnt_o), 128'b0010);
        tick(); tcdm_req_i = '0;
        drive(1, 32'h20, 1'b1, 4'h0, 32'h0); #1;
        tick(); tcdm_req_i = '0;
        chk_resp("be_rd", 1, 32'h11BB33DD);

        // address wrap and ignored byte offset on port 3
        drive(3, 32'h1008, 1'b0, 4'hF, 32'hCAFEF00D); #1;
        tick(); tcdm_req_i = '0;
        drive(3, 32'h8, 1'b1, 4'h0, 32'h0); #1;
        chk("wrap_gnt", 128'(tcdm_gnt_o), 128'b1000);
        tick(); tcdm_req_i = '0;
        chk_resp("wrap_rd", 3, 32'hCAFEF00D);
        drive(3, 32'hB, 1'b1, 4'h0, 32'h0); #1;
        tick(); tcdm_req_i = '0;
        chk_resp("wrap_lsb", 3, 32'hCAFEF00D);

        // be=0 write leaves the word untouched
        drive(2, 32'h8, 1'b0, 4'h0, 32'hFFFFFFFF); #1;
        tick(); tcdm_req_i = '0;
        chk_resp("be0_ack", 2, 32'h0);
        drive(2, 32'h8, 1'b1, 4'h0, 32'h0); #1;
        tick(); tcdm_req_i = '0;
        chk_resp("be0_noop", 2, 32'hCAFEF00D);

        // clear in the grant cycle drops the response and resets the pointer
        drive(2, 32'h10, 1'b1, 4'h0, 32'h0); clear_i = 1'b1; #1;
        chk("clr_gnt", 128'(tcdm_gnt_o), 128'b0100);
        tick(); tcdm_req_i = '0; clear_i = 1'b0;
        chk_resp("clr_drop", -1, 32'h0);

        // all ports requesting continuously
        drive(0, 32'h10, 1'b1, 4'h0, 32'h0);
        drive(1, 32'h20, 1'b1, 4'h0, 32'h0);
        drive(2, 32'h10, 1'b1, 4'h0, 32'h0);
        drive(3, 32'h20, 1'b1, 4'h0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_gnt", 128'(tcdm_gnt_o), 128'(4'b0001 << (k % 4)));
            tick();
            chk_resp("rr_rsp", k % 4, ((k % 2) == 0) ? 32'hDEADBEEF : 32'h11BB33DD);
        end
        tcdm_req_i = '0;
        tick();
        chk_resp("rr_idle", -1, 32'h0);

        // stall suppresses grants; port 2 wins once it drops
        stall_i = 1'b1;
        drive(2, 32'h10, 1'b1, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_gnt", 128'(tcdm_gnt_o), 128'h0);
            tick();
            chk_resp("stall_rsp", -1, 32'h0);
        end
        stall_i = 1'b0; #1;
        chk("unstall_gnt", 128'(tcdm_gnt_o), 128'b0100);
        tick(); tcdm_req_i = '0;
        chk_resp("unstall_rd", 2, 32'hDEADBEEF);

        // reset at the grant edge drops the response; memory survives
        drive(0, 32'h8, 1'b1, 4'h0, 32'h0); rst_ni = 1'b0; #1;
        tick(); tcdm_req_i = '0; rst_ni = 1'b1;
        chk_resp("rst_drop", -1, 32'h0);
        drive(0, 32'h1008, 1'b1, 4'h0, 32'h0);
        drive(1, 32'h8, 1'b1, 4'h0, 32'h0);
        drive(2, 32'h8, 1'b1, 4'h0, 32'h0);
        drive(3, 32'h8, 1'b1, 4'h0, 32'h0);
        #1;
        chk("post_rst_gnt", 128'(tcdm_gnt_o), 128'b0001);
        tick(); tcdm_req_i = '0;
        chk_resp("post_rst_rd", 0, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
